// File: rtl/ahb_master_arbiter_if.sv
// Bus-side bundle between the arbiter and the single AHB-Lite master.
// The arbiter drives the master's user command fields; HREADY and HRESP
// come straight from the AHB bus and are observed by the arbiter.
interface ahb_master_arbiter_if;
    logic        HREADY;
    logic        HRESP;
    logic        enable;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [1:0]  hselx;
    logic [2:0]  hburst;

    // Arbiter side: issues commands, watches bus status.
    modport master (
        input  HREADY, HRESP,
        output enable, addr, w_data, htrans, hsize, hwrite, hselx, hburst
    );

    // Master/bus side: consumes commands, reports status.
    modport slave (
        output HREADY, HRESP,
        input  enable, addr, w_data, htrans, hsize, hwrite, hselx, hburst
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Burst-granular arbiter sharing one AHB-Lite master's user command port
// between N_REQ requesters. A winner owns the port for its whole burst; the
// arbiter generates NONSEQ/SEQ, counts beats and acks each accepted address
// beat back to the owner.
// Optional feature macro: ARB_FIXED_PRIO_EN -- when defined, arbitration is
// fixed priority (lowest index wins) and no round-robin pointer exists.
module ahb_master_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]   req_wdata,
    input  logic [3*N_REQ-1:0]    req_hburst,
    input  logic [3*N_REQ-1:0]    req_hsize,
    input  logic [N_REQ-1:0]      req_hwrite,
    input  logic [2*N_REQ-1:0]    req_hselx,
    input  logic [4*N_REQ-1:0]    req_len,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      beat_ack,
    output logic [N_REQ-1:0]      err,
    ahb_master_arbiter_if.master  bus
);
    // Owner-indexed views are padded to a power of two so every owner value
    // addresses a real slot; padding slots read as zero and never win.
    localparam int NSLOT = 1 << IDX_W;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state;
    state_t            state_nxt;

    logic [NSLOT-1:0]  req_s;
    logic [31:0]       addr_s   [NSLOT];
    logic [31:0]       wdata_s  [NSLOT];
    logic [2:0]        hburst_s [NSLOT];
    logic [2:0]        hsize_s  [NSLOT];
    logic              hwrite_s [NSLOT];
    logic [1:0]        hselx_s  [NSLOT];
    logic [3:0]        len_s    [NSLOT];

    logic [IDX_W-1:0]  owner;
    logic [4:0]        beats_left;
    logic              first_beat;
    logic [31:0]       lat_addr;
    logic [2:0]        lat_hburst;
    logic [2:0]        lat_hsize;
    logic              lat_hwrite;
    logic [1:0]        lat_hselx;

    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              burst_end;

    generate
        for (genvar i = 0; i < NSLOT; i++) begin : g_slot
            if (i < N_REQ) begin : g_used
                assign req_s[i]    = req[i];
                assign addr_s[i]   = req_addr[32*i +: 32];
                assign wdata_s[i]  = req_wdata[32*i +: 32];
                assign hburst_s[i] = req_hburst[3*i +: 3];
                assign hsize_s[i]  = req_hsize[3*i +: 3];
                assign hwrite_s[i] = req_hwrite[i];
                assign hselx_s[i]  = req_hselx[2*i +: 2];
                assign len_s[i]    = req_len[4*i +: 4];
            end else begin : g_pad
                assign req_s[i]    = 1'b0;
                assign addr_s[i]   = '0;
                assign wdata_s[i]  = '0;
                assign hburst_s[i] = '0;
                assign hsize_s[i]  = '0;
                assign hwrite_s[i] = 1'b0;
                assign hselx_s[i]  = '0;
                assign len_s[i]    = '0;
            end
        end
    endgenerate

    // Beat count of a burst; INCR uses the requester's length field.
    function automatic logic [4:0] burst_beats(input logic [2:0] hb, input logic [3:0] len);
        case (hb)
            3'b000:         burst_beats = 5'd1;
            3'b001:         burst_beats = {1'b0, len} + 5'd1;
            3'b010, 3'b011: burst_beats = 5'd4;
            3'b100, 3'b101: burst_beats = 5'd8;
            default:        burst_beats = 5'd16;
        endcase
    endfunction

    // A burst ends on an error in either phase, or when the final data phase completes.
    assign burst_end = ((state == ADDR) && bus.HRESP) ||
                       ((state == DATA) && (bus.HRESP || bus.HREADY));

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest requesting index is the last write.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_s[IDX_W'(k)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // Pointer moves just past the finishing owner so a held request cannot starve others.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            rr_ptr <= '0;
        else if (burst_end)
            rr_ptr <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
    end

    // Round-robin: search from rr_ptr upward with wrap; nearest candidate is the last write.
    always_comb begin
        int scan;
        scan    = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan = (int'(rr_ptr) + k) % N_REQ;
            if (req_s[IDX_W'(scan)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(scan);
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: grant from IDLE, walk address beats, finish in the final data phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_vld) state_nxt = ADDR;
            ADDR: begin
                if (bus.HRESP)
                    state_nxt = IDLE;
                else if (bus.HREADY && (beats_left == 5'd1))
                    state_nxt = DATA;
            end
            DATA: if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst bookkeeping: latch owner and command at grant, count accepted beats, release.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner      <= '0;
            beats_left <= '0;
            first_beat <= 1'b0;
            gnt        <= '0;
            err        <= '0;
            lat_addr   <= '0;
            lat_hburst <= '0;
            lat_hsize  <= '0;
            lat_hwrite <= 1'b0;
            lat_hselx  <= '0;
        end else begin
            err <= '0;
            if ((state == IDLE) && win_vld) begin
                owner      <= win_idx;
                beats_left <= burst_beats(hburst_s[win_idx], len_s[win_idx]);
                first_beat <= 1'b1;
                gnt        <= N_REQ'(1) << win_idx;
                lat_addr   <= addr_s[win_idx];
                lat_hburst <= hburst_s[win_idx];
                lat_hsize  <= hsize_s[win_idx];
                lat_hwrite <= hwrite_s[win_idx];
                lat_hselx  <= hselx_s[win_idx];
            end else if (burst_end) begin
                // Remaining beats are dropped on error; gnt still names the owner here.
                gnt        <= '0;
                beats_left <= '0;
                if (bus.HRESP)
                    err <= gnt;
            end else if ((state == ADDR) && bus.HREADY) begin
                beats_left <= beats_left - 5'd1;
                first_beat <= 1'b0;
            end
        end
    end

    // Outputs: command phase signalling and the per-beat ack to the owner.
    always_comb begin
        bus.enable = 1'b0;
        bus.htrans = HT_IDLE;
        bus.w_data = '0;
        beat_ack   = '0;
        case (state)
            ADDR: begin
                bus.enable = 1'b1;
                bus.htrans = first_beat ? HT_NONSEQ : HT_SEQ;
                bus.w_data = wdata_s[owner];
                if (bus.HREADY)
                    beat_ack = gnt;
            end
            DATA: begin
                bus.enable = 1'b1;
                bus.w_data = wdata_s[owner];
            end
            default: ;
        endcase
    end

    assign bus.addr   = lat_addr;
    assign bus.hburst = lat_hburst;
    assign bus.hsize  = lat_hsize;
    assign bus.hwrite = lat_hwrite;
    assign bus.hselx  = lat_hselx;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Bench for ahb_master_arbiter: directed scenarios with hand-computed
// expectations, then randomized traffic, all checked every cycle against a
// transaction-level model (owner, beats accepted out of total).
module tb_ahb_master_arbiter;
    localparam int N  = 3;
    localparam int IW = 2;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_addr, req_wdata;
    logic [3*N-1:0]  req_hburst, req_hsize;
    logic [N-1:0]    req_hwrite;
    logic [2*N-1:0]  req_hselx;
    logic [4*N-1:0]  req_len;
    logic [N-1:0]    gnt, beat_ack, err;

    ahb_master_arbiter_if bus ();

    ahb_master_arbiter #(.N_REQ(N), .IDX_W(IW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .req(req), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_hburst(req_hburst), .req_hsize(req_hsize),
        .req_hwrite(req_hwrite), .req_hselx(req_hselx), .req_len(req_len),
        .gnt(gnt), .beat_ack(beat_ack), .err(err), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: a burst is (owner, total beats, beats accepted); address phase
    // while accepted < total, final data phase once they are equal.
    bit          m_busy = 1'b0;
    int          m_own = 0, m_total = 0, m_acked = 0, m_rr = 0, m_err_own = -1;
    logic [31:0] m_addr;
    logic [2:0]  m_hburst, m_hsize;
    logic        m_hwrite;
    logic [1:0]  m_hselx;

    function automatic int beats_of(input logic [2:0] hb, input logic [3:0] len);
        case (hb)
            3'b000:         return 1;
            3'b001:         return int'(len) + 1;
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] oh;
        bit           in_addr;
        oh      = m_busy ? (N'(1) << m_own) : '0;
        in_addr = m_busy && (m_acked < m_total);
        chk("gnt", gnt, oh);
        chk("enable", bus.enable, m_busy);
        chk("htrans", bus.htrans, !in_addr ? 0 : (m_acked == 0 ? 2 : 3));
        chk("beat_ack", beat_ack, (in_addr && bus.HREADY) ? oh : '0);
        chk("err", err, (m_err_own >= 0) ? (N'(1) << m_err_own) : '0);
        if (m_busy) begin
            chk("addr", bus.addr, m_addr);
            chk("hburst", bus.hburst, m_hburst);
            chk("hsize", bus.hsize, m_hsize);
            chk("hwrite", bus.hwrite, m_hwrite);
            chk("hselx", bus.hselx, m_hselx);
            chk("w_data", bus.w_data, req_wdata[32*m_own +: 32]);
        end else begin
            chk("w_data idle", bus.w_data, 0);
        end
    endtask

    task automatic model_update();
        int  start, j;
        bit  found;
        m_err_own = -1;
        found = 1'b0;
        start = FIXED ? 0 : m_rr;
        if (HRESET) begin
            m_busy = 1'b0; m_rr = 0; m_acked = 0; m_total = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                j = (start + k) % N;
                if (!found && req[j]) begin
                    found    = 1'b1;
                    m_busy   = 1'b1;
                    m_own    = j;
                    m_acked  = 0;
                    m_total  = beats_of(req_hburst[3*j +: 3], req_len[4*j +: 4]);
                    m_addr   = req_addr[32*j +: 32];
                    m_hburst = req_hburst[3*j +: 3];
                    m_hsize  = req_hsize[3*j +: 3];
                    m_hwrite = req_hwrite[j];
                    m_hselx  = req_hselx[2*j +: 2];
                end
            end
        end else if (bus.HRESP) begin
            m_err_own = m_own; m_busy = 1'b0; m_rr = (m_own + 1) % N;
        end else if (m_acked < m_total) begin
            if (bus.HREADY) m_acked++;
        end else if (bus.HREADY) begin
            m_busy = 1'b0; m_rr = (m_own + 1) % N;
        end
    endtask

    // One clock: inputs were set at the falling edge; check, advance model, wait next falling edge.
    task automatic step();
        #1;
        if (chk_en) compare();
        model_update();
        @(negedge HCLK);
    endtask

    task automatic set_rq(input int i, input bit r, input logic [31:0] a,
                          input logic [2:0] hb, input logic [3:0] len, input bit w);
        req[i]                = r;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = a ^ 32'hA5A5_0000;
        req_hburst[3*i +: 3]  = hb;
        req_len[4*i +: 4]     = len;
        req_hwrite[i]         = w;
        req_hsize[3*i +: 3]   = 3'b010;
        req_hselx[2*i +: 2]   = 2'b01;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req = '0;
        bus.HREADY = 1'b1;
        bus.HRESP = 1'b0;
        while (m_busy && n < 40) begin
            step();
            n++;
        end
        chk("drain bound", {31'd0, m_busy}, 0);
        step();
    endtask

    logic [N-1:0] g_log [14];
    logic [1:0]   h_log [14];
    logic [N-1:0] a_log [14];
    int           exp_ht [4] = '{2, 3, 3, 3};
    int           ack0, ack1;

    initial begin
        HRESET = 1'b1; req = '0; req_addr = '0; req_wdata = '0; req_hburst = '0;
        req_hsize = '0; req_hwrite = '0; req_hselx = '0; req_len = '0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        step();
        chk_en = 1'b1;
        #1;
        chk("rst gnt", gnt, 0); chk("rst enable", bus.enable, 0);
        chk("rst htrans", bus.htrans, 0); chk("rst err", err, 0);
        chk("rst addr", bus.addr, 0); chk("rst w_data", bus.w_data, 0);
        step();

        // 1: single write from requester 0
        HRESET = 1'b0;
        set_rq(0, 1'b1, 32'h100, 3'b000, 4'd0, 1'b1);
        #1; chk("t1 idle gnt", gnt, 0); chk("t1 idle htrans", bus.htrans, 0);
        step();
        #1; chk("t1 gnt", gnt, 3'b001); chk("t1 htrans", bus.htrans, 2);
        chk("t1 addr", bus.addr, 32'h100); chk("t1 ack", beat_ack, 3'b001);
        chk("t1 hwrite", bus.hwrite, 1);
        req[0] = 1'b0;
        step();
        #1; chk("t1 data enable", bus.enable, 1); chk("t1 data htrans", bus.htrans, 0);
        chk("t1 data ack", beat_ack, 0);
        step();
        #1; chk("t1 done enable", bus.enable, 0); chk("t1 done gnt", gnt, 0);
        step();

        // 2: two INCR4 requests together from reset
        HRESET = 1'b1; step(); HRESET = 1'b0;
        set_rq(0, 1'b1, 32'h200, 3'b011, 4'd0, 1'b0);
        set_rq(1, 1'b1, 32'h300, 3'b011, 4'd0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            #1; g_log[k] = gnt; h_log[k] = bus.htrans; a_log[k] = beat_ack;
            step();
        end
        ack0 = 0; ack1 = 0;
        for (int k = 0; k < 7; k++) if (a_log[k] == 3'b001) ack0++;
        for (int k = 7; k < 12; k++) if (a_log[k] == 3'b010) ack1++;
        chk("t2 gnt k0", g_log[0], 0);
        chk("t2 gnt k1", g_log[1], 3'b001);
        for (int k = 0; k < 4; k++) chk("t2 htrans seq", h_log[k+1], exp_ht[k]);
        chk("t2 ack0 count", ack0, 4);
        chk("t2 data phase", {g_log[5], h_log[5]}, {3'b001, 2'b00});
        chk("t2 gap", g_log[6], 0);
        chk("t2 second owner", g_log[7], FIXED ? 3'b001 : 3'b010);
        chk("t2 ack1 count", ack1, FIXED ? 0 : 4);
        chk("t2 third owner", g_log[13], 3'b001);
        drain();

        // 3: INCR of 6 beats with a two-cycle stall on beat 3
        set_rq(0, 1'b1, 32'h400, 3'b001, 4'd5, 1'b1);
        ack0 = 0;
        for (int j = 0; j < 11; j++) begin
            bus.HREADY = !(j == 3 || j == 4);
            #1;
            if (beat_ack[0]) ack0++;
            if (j == 3 || j == 4) begin
                chk("t3 stall htrans", bus.htrans, 3);
                chk("t3 stall ack", beat_ack, 0);
                chk("t3 stall addr", bus.addr, 32'h400);
            end
            if (j == 1) req[0] = 1'b0;
            step();
        end
        chk("t3 ack total", ack0, 6);
        #1; chk("t3 idle", bus.enable, 0);
        step();

        // 4: WRAP8 from requester 1, error on beat 4, requester 0 waiting
        set_rq(1, 1'b1, 32'h500, 3'b100, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bus.HRESP  = (i == 4);
            bus.HREADY = (i != 4);
            if (i == 1) req[1] = 1'b0;
            if (i == 2) set_rq(0, 1'b1, 32'h600, 3'b000, 4'd0, 1'b1);
            #1;
            if (i == 4) chk("t4 htrans at err", bus.htrans, 3);
            if (i == 5) begin
                chk("t4 err pulse", err, 3'b010); chk("t4 htrans", bus.htrans, 0);
                chk("t4 gnt", gnt, 0); chk("t4 enable", bus.enable, 0);
            end
            if (i == 6) begin
                chk("t4 next gnt", gnt, 3'b001); chk("t4 next htrans", bus.htrans, 2);
                chk("t4 next addr", bus.addr, 32'h600); chk("t4 err cleared", err, 0);
            end
            step();
        end
        drain();

        // 5: reset in the middle of an INCR16 at beat 7
        set_rq(0, 1'b1, 32'h700, 3'b111, 4'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            HRESET = (k == 7);
            if (k == 8) begin
                set_rq(0, 1'b1, 32'h800, 3'b000, 4'd0, 1'b0);
                set_rq(1, 1'b1, 32'h900, 3'b000, 4'd0, 1'b0);
            end
            #1;
            if (k == 7) chk("t5 beat7 htrans", bus.htrans, 3);
            if (k == 8) begin
                chk("t5 gnt", gnt, 0); chk("t5 enable", bus.enable, 0);
                chk("t5 htrans", bus.htrans, 0); chk("t5 err", err, 0);
            end
            if (k == 9) chk("t5 rr after reset", gnt, 3'b001);
            step();
        end
        drain();

        // Randomized traffic; the owner's command fields stay put while it holds the port.
        for (int c = 0; c < 4000; c++) begin
            HRESET     = ($urandom_range(0, 299) == 0);
            bus.HREADY = ($urandom_range(0, 3) != 0);
            bus.HRESP  = !bus.HREADY && ($urandom_range(0, 29) == 0);
            for (int i = 0; i < N; i++) begin
                if (m_busy && m_own == i) begin
                    req[i] = ($urandom_range(0, 1) == 1);
                end else begin
                    req[i]                = ($urandom_range(0, 2) != 0);
                    req_addr[32*i +: 32]  = $urandom;
                    req_hburst[3*i +: 3]  = 3'($urandom);
                    req_hsize[3*i +: 3]   = 3'($urandom);
                    req_len[4*i +: 4]     = 4'($urandom);
                    req_hwrite[i]         = 1'($urandom);
                    req_hselx[2*i +: 2]   = 2'($urandom);
                end
                req_wdata[32*i +: 32] = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
